// File: rtl/firdec2_pkg.sv
// Shared defaults, output bit-slice derivation, FSM states and coefficient
// table for the decimate-by-2 I/Q FIR.
package firdec2_pkg;

    localparam int DEF_IN_WIDTH   = 18;
    localparam int DEF_COEF_WIDTH = 18;
    localparam int DEF_OUT_WIDTH  = 24;
    localparam int DEF_NTAPS      = 64;
    localparam int DEF_ACC_WIDTH  = 48;

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    // Top accumulator bit kept in the output (unity-gain product MSB).
    function automatic int round_msb(input int in_width, input int coef_width);
        return in_width + coef_width - 2;
    endfunction

    function automatic int round_lsb(input int in_width, input int coef_width, input int out_width);
        return round_msb(in_width, coef_width) - out_width + 1;
    endfunction

    // Set 0 is the production filter; set 1 is a flat filter whose taps sum to 2^18.
    function automatic int coef_value(input int coef_set, input int k, input int ntaps);
        if (coef_set == 1) begin
            return (1 << 18) / ntaps;
        end
        return ((k * 29 + 7) % 61) * 97 - 2900;
    endfunction

endpackage

// File: rtl/firdec2_firrom.sv
// Coefficient ROM for firdec2: NTAPS x COEF_WIDTH, one-cycle registered read.
module firrom
    import firdec2_pkg::*;
#(
    parameter int NTAPS      = DEF_NTAPS,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int COEF_SET   = 0
) (
    input  logic                     clock,
    input  logic [$clog2(NTAPS)-1:0] addr,
    output logic [COEF_WIDTH-1:0]    data
);

    logic [COEF_WIDTH-1:0] rom [NTAPS];

    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            rom[k] = COEF_WIDTH'(coef_value(COEF_SET, int'(k), NTAPS));
        end
    end

    always_ff @(posedge clock) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/firdec2.sv
// Decimate-by-2 I/Q FIR: circular sample buffer, one serial MAC per output,
// round-half-up with saturation to OUT_WIDTH.
module firdec2
    import firdec2_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int NTAPS      = DEF_NTAPS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int COEF_SET   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_strobe,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic [IN_WIDTH-1:0]  in_data_q,
    output logic                 out_strobe,
    output logic [OUT_WIDTH-1:0] out_data_i,
    output logic [OUT_WIDTH-1:0] out_data_q,
    output logic                 overrun
);

    localparam int AW  = $clog2(NTAPS);
    localparam int PW  = IN_WIDTH + COEF_WIDTH;
    localparam int MSB = round_msb(IN_WIDTH, COEF_WIDTH);
    localparam int LSB = MSB - OUT_WIDTH + 1;
    localparam int RW  = ACC_WIDTH - LSB + 1;
    localparam logic signed [RW-1:0] OUT_MAX = RW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] OUT_MIN = RW'(-(2 ** (OUT_WIDTH - 1)));

    state_t state, state_nxt;

    logic [AW-1:0] wr_ptr, base, k;
    logic [AW:0]   fill;
    logic          phase;
    logic          trigger, rd_en;

    logic [2*IN_WIDTH-1:0] ram [NTAPS];
    logic [2*IN_WIDTH-1:0] rd_word;
    logic [AW-1:0]         rd_addr;
    logic [COEF_WIDTH-1:0] coef_word;

    logic signed [IN_WIDTH-1:0]   samp_i, samp_q;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [PW-1:0]         prod_i, prod_q;
    logic signed [ACC_WIDTH-1:0]  acc_i, acc_q;
    logic v1, first1, last1, v2, first2, last2, done3;

    assign trigger = in_strobe && phase && (fill >= (AW+1)'(NTAPS - 1));
    assign rd_en   = (state == MAC);
    assign rd_addr = base - k;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = MAC;
            MAC:     if (k == AW'(NTAPS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            base    <= '0;
            k       <= '0;
            phase   <= 1'b0;
            fill    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_strobe) begin
                wr_ptr <= wr_ptr + 1'b1;
                phase  <= ~phase;
                if (fill != (AW+1)'(NTAPS)) fill <= fill + 1'b1;
            end
            if (trigger && state == MAC) overrun <= 1'b1;
            if (trigger && state == IDLE) begin
                base <= wr_ptr;
                k    <= '0;
            end else if (state == MAC) begin
                k <= k + 1'b1;
            end
        end
    end

    // Writes are never held off, so a strobe landing less than NTAPS cycles
    // after a trigger replaces the oldest entry before tap NTAPS-1 reads it.
    always_ff @(posedge clock) begin
        if (in_strobe && !reset) ram[wr_ptr] <= {in_data_i, in_data_q};
        rd_word <= ram[rd_addr];
    end

    firrom #(
        .NTAPS     (NTAPS),
        .COEF_WIDTH(COEF_WIDTH),
        .COEF_SET  (COEF_SET)
    ) u_rom (
        .clock(clock),
        .addr (k),
        .data (coef_word)
    );

    assign samp_i = rd_word[2*IN_WIDTH-1:IN_WIDTH];
    assign samp_q = rd_word[IN_WIDTH-1:0];
    assign coef   = coef_word;

    always_ff @(posedge clock) begin
        first1 <= (k == '0);
        last1  <= (k == AW'(NTAPS - 1));
        first2 <= first1;
        last2  <= last1;
        prod_i <= samp_i * coef;
        prod_q <= samp_q * coef;
        if (v2) begin
            acc_i <= first2 ? ACC_WIDTH'(prod_i) : acc_i + ACC_WIDTH'(prod_i);
            acc_q <= first2 ? ACC_WIDTH'(prod_q) : acc_q + ACC_WIDTH'(prod_q);
        end
    end

    function automatic logic [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [RW-1:0] hi, rb, r;
        hi = {a[ACC_WIDTH-1], a[ACC_WIDTH-1:LSB]};
        rb = {{(RW-1){1'b0}}, a[LSB-1]};
        r  = hi + rb;
        if (r > OUT_MAX) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        if (r < OUT_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        return r[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            done3      <= 1'b0;
            out_strobe <= 1'b0;
            out_data_i <= '0;
            out_data_q <= '0;
        end else begin
            v1         <= rd_en;
            v2         <= v1;
            done3      <= v2 && last2;
            out_strobe <= done3;
            if (done3) begin
                out_data_i <= round_sat(acc_i);
                out_data_q <= round_sat(acc_q);
            end
        end
    end

endmodule

// File: tb/tb_firdec2.sv
// Self-checking bench for firdec2: production-filter DUT and flat-filter DUT
// driven by the same stimulus and compared against a sample-history FIR model.
module tb_firdec2;

    localparam int N  = 64;
    localparam int IW = 18;
    localparam int OW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_strobe;
    logic [IW-1:0] in_data_i, in_data_q;
    logic          ostb [2];
    logic [OW-1:0] oi [2];
    logic [OW-1:0] oq [2];
    logic          ovr [2];

    always #5 clock = ~clock;

    firdec2 #(.IN_WIDTH(18), .COEF_WIDTH(18), .OUT_WIDTH(24), .NTAPS(64), .ACC_WIDTH(48), .COEF_SET(0)) dut (
        .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data_i(in_data_i), .in_data_q(in_data_q),
        .out_strobe(ostb[0]), .out_data_i(oi[0]), .out_data_q(oq[0]), .overrun(ovr[0]));

    firdec2 #(.IN_WIDTH(18), .COEF_WIDTH(18), .OUT_WIDTH(24), .NTAPS(64), .ACC_WIDTH(48), .COEF_SET(1)) dut_sat (
        .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data_i(in_data_i), .in_data_q(in_data_q),
        .out_strobe(ostb[1]), .out_data_i(oi[1]), .out_data_q(oq[1]), .overrun(ovr[1]));

    typedef struct {
        int cyc;
        int i0, q0, i1, q1;
    } exp_t;

    typedef struct {
        int xi, xq;
        int ei, eq;
    } vec_t;

    exp_t expq[$];
    int   hist_i[$], hist_q[$];
    int   cyc = 0, n_checks = 0, n_fail = 0;
    int   cnt, busy_until;
    bit   phase_m, ovr_m;
    int   held_i [2], held_q [2];
    int   seen [2];

    function automatic int coef(input int d, input int k);
        if (d == 1) return 4096;
        return ((k * 29 + 7) % 61) * 97 - 2900;
    endfunction

    function automatic int clamp_round(input longint acc);
        longint r;
        r = (acc + 1024) >>> 11;
        if (r > 8388607) r = 8388607;
        if (r < -8388608) r = -8388608;
        return int'(r);
    endfunction

    // y[n] = sum h[k]*x[n-k] over the history of samples since reset
    function automatic int fir_out(input int d, input bit use_q);
        longint acc = 0;
        int n = hist_i.size() - 1;
        for (int k = 0; k < N; k++)
            acc += longint'(coef(d, k)) * longint'(use_q ? hist_q[n-k] : hist_i[n-k]);
        return clamp_round(acc);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic sample_outputs();
        bit   due;
        exp_t e;
        due = (expq.size() > 0) && (expq[0].cyc == cyc);
        if (due) e = expq.pop_front();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out_strobe[%0d]", d), int'(ostb[d]), int'(due));
            if (ostb[d]) seen[d]++;
            if (due) begin
                held_i[d] = (d == 0) ? e.i0 : e.i1;
                held_q[d] = (d == 0) ? e.q0 : e.q1;
            end
            check($sformatf("out_data_i[%0d]", d), int'($signed(oi[d])), held_i[d]);
            check($sformatf("out_data_q[%0d]", d), int'($signed(oq[d])), held_q[d]);
            check($sformatf("overrun[%0d]", d), int'(ovr[d]), int'(ovr_m));
        end
    endtask

    task automatic step(input bit stb, input int di, input int dq, input bit rst);
        exp_t e;
        reset     = rst;
        in_strobe = stb;
        in_data_i = IW'(di);
        in_data_q = IW'(dq);
        if (rst) begin
            hist_i.delete(); hist_q.delete(); expq.delete();
            cnt = 0; phase_m = 0; ovr_m = 0; busy_until = -1000;
            held_i = '{0, 0}; held_q = '{0, 0};
        end else if (stb) begin
            hist_i.push_back(di);
            hist_q.push_back(dq);
            cnt++;
            if (phase_m && cnt >= N) begin
                if (cyc > busy_until) begin
                    busy_until = cyc + N;
                    e.cyc = cyc + N + 3;
                    e.i0 = fir_out(0, 0); e.q0 = fir_out(0, 1);
                    e.i1 = fir_out(1, 0); e.q1 = fir_out(1, 1);
                    expq.push_back(e);
                end else begin
                    ovr_m = 1;
                end
            end
            phase_m = !phase_m;
        end
        @(posedge clock);
        #1;
        sample_outputs();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic feed(input int n, input int gap, input bit rnd, input int vi, input int vq);
        int a, b;
        for (int s = 0; s < n; s++) begin
            a = vi; b = vq;
            if (rnd) begin
                a = int'($urandom_range(0, 262143)) - 131072;
                b = int'($urandom_range(0, 262143)) - 131072;
            end
            step(1, a, b, 0);
            idle(gap - 1);
        end
    endtask

    initial begin
        vec_t   vecs [5];
        longint hsum;
        int     base_seen;

        // flat filter: steady output is x*128, clipped to the 24-bit range
        vecs[0] = '{xi: 1,      xq: -1,      ei: 128,     eq: -128};
        vecs[1] = '{xi: 65535,  xq: -65536,  ei: 8388480, eq: -8388608};
        vecs[2] = '{xi: 65536,  xq: -65537,  ei: 8388607, eq: -8388608};
        vecs[3] = '{xi: 131071, xq: -131072, ei: 8388607, eq: -8388608};
        vecs[4] = '{xi: 0,      xq: 3,       ei: 0,       eq: 384};

        held_i = '{0, 0}; held_q = '{0, 0}; seen = '{0, 0};
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 77, -77, 1);
        check("reset out_strobe", int'(ostb[0]), 0);
        check("reset out_data_i", int'($signed(oi[0])), 0);
        check("reset overrun", int'(ovr[0]), 0);

        foreach (vecs[v]) begin
            feed(N, 66, 0, vecs[v].xi, vecs[v].xq);
            idle(N + 8);
            check($sformatf("table%0d sat out_i", v), int'($signed(oi[1])), vecs[v].ei);
            check($sformatf("table%0d sat out_q", v), int'($signed(oq[1])), vecs[v].eq);
        end

        feed(N, 66, 0, 0, 0);
        feed(1, 66, 0, 65536, 0);
        feed(65, 66, 0, 0, 0);

        for (int s = 0; s < 100; s++) begin
            step(1, int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072, 0);
            idle(int'($urandom_range(63, 79)));
        end

        feed(80, 66, 0, -131072, -131072);
        hsum = 0;
        for (int k = 0; k < N; k++) hsum += coef(0, k);
        check("dc out_i", int'($signed(oi[0])), clamp_round(-131072 * hsum));
        check("dc out_q", int'($signed(oq[0])), clamp_round(-131072 * hsum));

        feed(40, 40, 0, -131072, -131072);
        check("timing overrun clear", int'(ovr[0]), 0);
        feed(40, 20, 0, -131072, -131072);
        check("overrun set", int'(ovr[0]), 1);
        idle(N + 20);

        step(1, 1000, -1000, 0);
        idle(65);
        step(1, 2000, -2000, 0);
        idle(9);
        base_seen = seen[0];
        step(1, 5000, 5000, 1);
        idle(80);
        check("reset-mid-mac no strobe", seen[0] - base_seen, 0);
        check("reset-mid-mac out_i", int'($signed(oi[0])), 0);
        check("reset-mid-mac overrun", int'(ovr[0]), 0);
        feed(N - 1, 66, 1, 0, 0);
        idle(N + 10);
        check("refill no early output", seen[0] - base_seen, 0);
        feed(1, 66, 1, 0, 0);
        idle(N + 10);
        check("refill first output", seen[0] - base_seen, 1);

        check("pending outputs", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
